iob_pfsm_input_cond: RTL and testbench

IOB_PFSM_INPUT_COND -- requirements
Module: iob_pfsm_input_cond

---
 rtl/iob_pfsm_input_cond.sv | 129 ++++++++++++
 tb/tb_iob_pfsm_input_cond.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_pfsm_input_cond.sv
// -----------------------------------------------------------------------------
// iob_pfsm_input_cond
//
// Conditions raw asynchronous inputs before they reach a PFSM. Each bit is
// synchronised (2 flops), optionally inverted, debounced over a programmable
// number of samples, then presented as a level or as a one-cycle edge pulse.
//
// Ports
//   clk_i             : system clock, all registers on the rising edge
//   rst_i             : synchronous active-high reset, overrides cke_i/en_i
//   cke_i             : clock enable, 0 = every register holds
//   en_i              : conditioning enable, 0 = debounce/output state cleared
//   debounce_period_i : consecutive differing samples to accept a level (0 -> 1)
//   mode_i            : per-bit mode [2i+1:2i]: 00 level, 01 rise, 10 fall, 11 any
//   invert_i          : per-bit polarity inversion after synchronisation
//   inputs_i          : raw inputs, asynchronous to clk_i
//   input_ports_o     : registered conditioned bits
//   changed_o         : registered strobe, high when input_ports_o just changed
// -----------------------------------------------------------------------------
module iob_pfsm_input_cond #(
  parameter int INPUT_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cke_i,
  input  logic                   en_i,
  input  logic [CNT_W-1:0]       debounce_period_i,
  input  logic [2*INPUT_W-1:0]   mode_i,
  input  logic [INPUT_W-1:0]     invert_i,
  input  logic [INPUT_W-1:0]     inputs_i,
  output logic [INPUT_W-1:0]     input_ports_o,
  output logic                   changed_o
);

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_ANY   = 2'b11
  } mode_e;

  logic [INPUT_W-1:0] sync1_q, sync2_q;
  logic [INPUT_W-1:0] stable_q, stable_d;
  logic [INPUT_W-1:0] prev_q;
  logic [CNT_W-1:0]   cnt_q [INPUT_W];
  logic [CNT_W-1:0]   cnt_d [INPUT_W];
  logic [INPUT_W-1:0] out_q, out_d;
  logic               changed_q, changed_d;

  logic [CNT_W-1:0]   period_eff;
  logic [INPUT_W-1:0] s;
  logic [INPUT_W-1:0] rise, fall;

  // Debounce and output selection for all bits.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    stable_d  = stable_q;
    out_d     = '0;
    changed_d = 1'b0;
    for (int i = 0; i < INPUT_W; i++) begin
      cnt_d[i] = '0;
    end

    period_eff = (debounce_period_i == '0) ? CNT_W'(1) : debounce_period_i;
    s          = sync2_q ^ invert_i;
    rise       = stable_q & ~prev_q;
    fall       = ~stable_q & prev_q;

    for (int i = 0; i < INPUT_W; i++) begin
      if (s[i] != stable_q[i]) begin
        // '>=' lets a period lowered mid-count accept on the next differing
        // sample instead of letting the counter run on towards a wrap.
        if (cnt_q[i] >= period_eff - CNT_W'(1)) begin
          stable_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end

      unique case (mode_e'(mode_i[2*i +: 2]))
        MODE_LEVEL: out_d[i] = stable_q[i];
        MODE_RISE:  out_d[i] = rise[i];
        MODE_FALL:  out_d[i] = fall[i];
        MODE_ANY:   out_d[i] = rise[i] | fall[i];
        default:    out_d[i] = 1'b0;
      endcase
    end

    changed_d = (out_d != out_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      prev_q    <= '0;
      cnt_q     <= '{default: '0};
      out_q     <= '0;
      changed_q <= 1'b0;
    end else if (cke_i) begin
      // Synchronisers keep sampling even while conditioning is disabled.
      sync1_q <= inputs_i;
      sync2_q <= sync1_q;
      if (en_i) begin
        stable_q  <= stable_d;
        prev_q    <= stable_q;
        cnt_q     <= cnt_d;
        out_q     <= out_d;
        changed_q <= changed_d;
      end else begin
        // Clearing prev together with stable means re-enabling cannot
        // produce a pulse from the cleared state itself.
        stable_q  <= '0;
        prev_q    <= '0;
        cnt_q     <= '{default: '0};
        out_q     <= '0;
        changed_q <= 1'b0;
      end
    end
  end

  assign input_ports_o = out_q;
  assign changed_o     = changed_q;

endmodule

// File: tb/tb_iob_pfsm_input_cond.sv
// -----------------------------------------------------------------------------
// tb_iob_pfsm_input_cond
//
// Directed scenarios with fixed expected values, followed by a randomized run
// compared every cycle against a behavioural model built from run lengths of
// differing samples and the history of the accepted level.
// -----------------------------------------------------------------------------
module tb_iob_pfsm_input_cond;

  localparam int INPUT_W = 4;
  localparam int CNT_W   = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cke = 1'b1;
  logic                 en  = 1'b1;
  logic [CNT_W-1:0]     period = '0;
  logic [2*INPUT_W-1:0] mode = '0;
  logic [INPUT_W-1:0]   inv = '0;
  logic [INPUT_W-1:0]   inputs = '0;
  logic [INPUT_W-1:0]   ports;
  logic                 changed;

  int n_checks = 0;
  int n_errors = 0;

  iob_pfsm_input_cond #(.INPUT_W(INPUT_W), .CNT_W(CNT_W)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .cke_i             (cke),
    .en_i              (en),
    .debounce_period_i (period),
    .mode_i            (mode),
    .invert_i          (inv),
    .inputs_i          (inputs),
    .input_ports_o     (ports),
    .changed_o         (changed)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [INPUT_W-1:0] m_pipe [2];
  logic [INPUT_W-1:0] m_level;      // accepted (debounced) level
  logic [INPUT_W-1:0] m_level_last; // accepted level one enabled cycle ago
  int                 m_run [INPUT_W];
  logic [INPUT_W-1:0] m_out;
  logic               m_chg;

  task automatic model_clear();
    m_level      = '0;
    m_level_last = '0;
    for (int i = 0; i < INPUT_W; i++) m_run[i] = 0;
    m_out = '0;
    m_chg = 1'b0;
  endtask

  task automatic model_step();
    logic [INPUT_W-1:0] seen, nxt_level, nxt_out;
    int p;
    if (rst) begin
      m_pipe[0] = '0;
      m_pipe[1] = '0;
      model_clear();
    end else if (cke) begin
      if (en) begin
        p    = (period == 0) ? 1 : int'(period);
        seen = m_pipe[1] ^ inv;
        nxt_level = m_level;
        for (int i = 0; i < INPUT_W; i++) begin
          case (mode[2*i +: 2])
            2'b00:   nxt_out[i] = m_level[i];
            2'b01:   nxt_out[i] = m_level[i] && !m_level_last[i];
            2'b10:   nxt_out[i] = !m_level[i] && m_level_last[i];
            default: nxt_out[i] = m_level[i] != m_level_last[i];
          endcase
          if (seen[i] == m_level[i]) begin
            m_run[i] = 0;
          end else if (m_run[i] + 1 >= p) begin
            nxt_level[i] = seen[i];
            m_run[i] = 0;
          end else begin
            m_run[i] = m_run[i] + 1;
          end
        end
        m_chg        = (nxt_out != m_out);
        m_level_last = m_level;
        m_level      = nxt_level;
        m_out        = nxt_out;
      end else begin
        model_clear();
      end
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = inputs;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One rising edge, model update, then compare away from the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_ports", 32'(ports), 32'(m_out));
    check("model_changed", 32'(changed), 32'(m_chg));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      tick();
      check("reset_ports", 32'(ports), 32'h0);
      check("reset_changed", 32'(changed), 32'h0);
    end
    rst = 1'b0;
  endtask

  initial begin
    m_pipe[0] = '0;
    m_pipe[1] = '0;
    model_clear();

    // Reset with all inputs high: nothing propagates during or just after.
    inputs = 4'hF;
    period = 16'd3;
    do_reset();
    tick();
    check("post_reset_ports", 32'(ports), 32'h0);
    check("post_reset_changed", 32'(changed), 32'h0);

    // Level mode, P=3: bit0 appears at E0+5 with a single changed strobe.
    inputs = 4'h0;
    do_reset();
    inputs = 4'h1;
    repeat (5) begin
      tick();
      check("lvl_wait", 32'(ports), 32'h0);
    end
    tick();
    check("lvl_ports", 32'(ports), 32'h1);
    check("lvl_changed", 32'(changed), 32'h1);
    tick();
    check("lvl_hold", 32'(ports), 32'h1);
    check("lvl_changed_end", 32'(changed), 32'h0);

    // Glitch shorter than P=4 is discarded.
    inputs = 4'h0;
    period = 16'd4;
    do_reset();
    inputs = 4'h2;
    repeat (3) tick();
    inputs = 4'h0;
    repeat (10) begin
      tick();
      check("glitch_ports", 32'(ports), 32'h0);
      check("glitch_changed", 32'(changed), 32'h0);
    end

    // Rising-pulse mode on bit2, P=1.
    period = 16'd1;
    mode   = 8'h10;
    do_reset();
    inputs = 4'h4;
    repeat (3) begin
      tick();
      check("rise_wait", 32'(ports), 32'h0);
    end
    tick();
    check("rise_pulse", 32'(ports), 32'h4);
    check("rise_changed_on", 32'(changed), 32'h1);
    tick();
    check("rise_pulse_end", 32'(ports), 32'h0);
    check("rise_changed_off", 32'(changed), 32'h1);
    tick();
    check("rise_changed_idle", 32'(changed), 32'h0);
    inputs = 4'h0;
    repeat (8) begin
      tick();
      check("rise_no_fall_pulse", 32'(ports), 32'h0);
    end

    // Period 0 behaves as 1; inverted bit3 with input low reads as high.
    mode   = 8'h00;
    period = 16'd0;
    inv    = 4'h8;
    do_reset();
    tick();
    check("p0_first", 32'(ports), 32'h0);
    tick();
    check("p0_ports", 32'(ports), 32'h8);
    check("p0_changed", 32'(changed), 32'h1);

    // P=8: disable mid-count, then a full 8 samples are needed again.
    inv    = 4'h0;
    period = 16'd8;
    do_reset();
    inputs = 4'h2;
    repeat (12) tick();
    check("en_pre", 32'(ports), 32'h2);
    inputs = 4'h3;
    repeat (7) tick();
    check("en_midcount", 32'(ports), 32'h2);
    en = 1'b0;
    tick();
    check("en_off_ports", 32'(ports), 32'h0);
    check("en_off_changed", 32'(changed), 32'h0);
    tick();
    en = 1'b1;
    repeat (8) begin
      tick();
      check("en_restart_wait", 32'(ports), 32'h0);
    end
    tick();
    check("en_restart_ports", 32'(ports), 32'h3);
    check("en_restart_changed", 32'(changed), 32'h1);

    // Randomized run against the model (checked inside tick()).
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      cke = ($urandom_range(0, 9) != 0);
      en  = ($urandom_range(0, 39) != 0);
      for (int b = 0; b < INPUT_W; b++) begin
        if ($urandom_range(0, 7) == 0) inputs[b] = ~inputs[b];
      end
      if ((c % 64) == 0) period = CNT_W'($urandom_range(0, 5));
      if ((c % 150) == 0) mode = 8'($urandom);
      if ((c % 200) == 0) inv = 4'($urandom);
      tick();
    end
    rst = 1'b0;
    cke = 1'b1;
    en  = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
